// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the shared single-ALU / single-memory datapath.
// Steps ADD, LW and SW through fetch/decode/execute/memory/writeback with a memory timeout trap.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALU_Control,
    output logic             busy,
    output logic             illegal,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam int              WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [5:0]      OP_R      = 6'b000001;
    localparam logic [5:0]      OP_LW     = 6'b000100;
    localparam logic [5:0]      OP_SW     = 6'b000010;
    localparam logic [5:0]      FN_ADD    = 6'b100000;
    localparam logic [3:0]      ALU_ADD   = 4'b0101;
    localparam logic [1:0]      TC_ILL    = 2'b01;
    localparam logic [1:0]      TC_MEM    = 2'b10;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        trap_q, trap_next;
    logic              retire;
    logic              timed_out;
    logic              in_mem_state;

    // mem_ready arriving on the timeout cycle wins, so it masks the trap here.
    assign timed_out    = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_V) && !mem_ready;
    assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign trap_cause   = trap_q;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            trap_q      <= 2'b00;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state  <= state_next;
            trap_q <= trap_next;
            if (state_next != state || mem_ready)
                wait_cnt <= '0;
            else if (in_mem_state)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        trap_next   = trap_q;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALU_Control = 4'b0000;
        busy        = (state != S_IDLE) && (state != S_TRAP);
        illegal     = 1'b0;

        case (state)
            S_IDLE: begin
                if (run)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead     = 1'b1;
                ALUSrcB     = 2'b01;
                ALU_Control = ALU_ADD;
                IRWrite     = mem_ready;
                PCWrite     = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    trap_next  = TC_MEM;
                end
            end
            S_DECODE: begin
                if (opcode == OP_R && funct == FN_ADD) begin
                    state_next = S_EXEC_R;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_ADDR;
                end else begin
                    state_next = S_TRAP;
                    trap_next  = TC_ILL;
                end
            end
            S_EXEC_R: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_ADD;
                state_next  = S_WB_R;
            end
            S_WB_R: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_Control = ALU_ADD;
                state_next  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_next = S_WB_LD;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    trap_next  = TC_MEM;
                end
            end
            S_WB_LD: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = run ? S_FETCH : S_IDLE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    trap_next  = TC_MEM;
                end
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors against hand-computed constants.
// Built with MEM_TIMEOUT = 4 so the timeout boundary is reachable in a few cycles.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALU_Control;
    logic        busy, illegal;
    logic [1:0]  trap_cause;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALU_Control,busy,illegal,trap_cause}
    logic [18:0] out_vec;
    assign out_vec = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
                      ALUSrcA, ALUSrcB, ALU_Control, busy, illegal, trap_cause};

    localparam logic [18:0] V_IDLE      = 19'b0_0_0_0_0_0_0_0_0_00_0000_0_0_00;
    localparam logic [18:0] V_FETCH     = 19'b0_0_0_1_0_0_0_0_0_01_0101_1_0_00;
    localparam logic [18:0] V_FETCH_RDY = 19'b1_1_0_1_0_0_0_0_0_01_0101_1_0_00;
    localparam logic [18:0] V_DECODE    = 19'b0_0_0_0_0_0_0_0_0_00_0000_1_0_00;
    localparam logic [18:0] V_EXEC_R    = 19'b0_0_0_0_0_0_0_0_1_00_0101_1_0_00;
    localparam logic [18:0] V_WB_R      = 19'b0_0_0_0_0_0_1_1_0_00_0000_1_0_00;
    localparam logic [18:0] V_ADDR      = 19'b0_0_0_0_0_0_0_0_1_10_0101_1_0_00;
    localparam logic [18:0] V_MEM_RD    = 19'b0_0_1_1_0_0_0_0_0_00_0000_1_0_00;
    localparam logic [18:0] V_WB_LD     = 19'b0_0_0_0_0_1_0_1_0_00_0000_1_0_00;
    localparam logic [18:0] V_MEM_WR    = 19'b0_0_1_0_1_0_0_0_0_00_0000_1_0_00;
    localparam logic [18:0] V_TRAP_ILL  = 19'b0_0_0_0_0_0_0_0_0_00_0000_0_1_01;
    localparam logic [18:0] V_TRAP_TO   = 19'b0_0_0_0_0_0_0_0_0_00_0000_0_1_10;

    localparam logic [5:0] OP_R   = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000100;
    localparam logic [5:0] OP_SW  = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control),
        .busy(busy), .illegal(illegal), .trap_cause(trap_cause), .instr_count(instr_count),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already applied, compare at negedge, return at posedge+1.
    task automatic cycle(input string tag, input logic [18:0] exp);
        @(negedge clk);
        check(tag, {13'b0, out_vec}, {13'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b0;
        funct     = 6'b0;
        @(negedge clk);
        check("rst_vec", {13'b0, out_vec}, 32'd0);
        check("rst_cnt", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        cycle("idle", V_IDLE);

        // ADD with run held, followed directly by LW with three wait cycles
        opcode = OP_R; funct = FN_ADD; run = 1'b1; mem_ready = 1'b1;
        cycle("add_idle", V_IDLE);
        cycle("add_fetch", V_FETCH_RDY);
        cycle("add_dec", V_DECODE);
        cycle("add_exec", V_EXEC_R);
        cycle("add_wb", V_WB_R);
        check("add_cnt", instr_count, 32'd1);
        opcode = OP_LW;
        cycle("lw_fetch", V_FETCH_RDY);
        cycle("lw_dec", V_DECODE);
        cycle("lw_addr", V_ADDR);
        mem_ready = 1'b0;
        repeat (3) cycle("lw_wait", V_MEM_RD);
        mem_ready = 1'b1;
        cycle("lw_mem", V_MEM_RD);
        run = 1'b0;
        cycle("lw_wb", V_WB_LD);
        check("lw_cnt", instr_count, 32'd2);
        cycle("lw_idle", V_IDLE);

        // SW, run dropped while the write waits
        opcode = OP_SW; run = 1'b1; mem_ready = 1'b1;
        cycle("sw_idle", V_IDLE);
        cycle("sw_fetch", V_FETCH_RDY);
        cycle("sw_dec", V_DECODE);
        cycle("sw_addr", V_ADDR);
        mem_ready = 1'b0;
        cycle("sw_wait", V_MEM_WR);
        run = 1'b0;
        repeat (2) cycle("sw_wait", V_MEM_WR);
        mem_ready = 1'b1;
        cycle("sw_mem", V_MEM_WR);
        check("sw_cnt", instr_count, 32'd3);
        mem_ready = 1'b0;
        cycle("sw_idle_after", V_IDLE);

        // illegal opcode; run and mem_ready toggled in TRAP
        opcode = 6'b111111; run = 1'b1; mem_ready = 1'b1;
        cycle("ill_idle", V_IDLE);
        cycle("ill_fetch", V_FETCH_RDY);
        cycle("ill_dec", V_DECODE);
        for (int i = 0; i < 4; i++) begin
            run       = (i % 2 == 1);
            mem_ready = (i % 2 == 0);
            cycle("ill_trap", V_TRAP_ILL);
        end
        check("ill_cnt", instr_count, 32'd3);

        // R-type with an unsupported funct
        do_reset();
        opcode = OP_R; funct = 6'b000000; run = 1'b1; mem_ready = 1'b1;
        cycle("fn_idle", V_IDLE);
        cycle("fn_fetch", V_FETCH_RDY);
        cycle("fn_dec", V_DECODE);
        run = 1'b0;
        cycle("fn_trap", V_TRAP_ILL);
        run = 1'b1;
        cycle("fn_trap2", V_TRAP_ILL);

        // fetch timeout: counter 0..4 across five FETCH cycles, then TRAP
        do_reset();
        opcode = OP_R; funct = FN_ADD; run = 1'b1; mem_ready = 1'b0;
        cycle("to_idle", V_IDLE);
        repeat (5) cycle("to_fetch", V_FETCH);
        cycle("to_trap", V_TRAP_TO);
        cycle("to_trap2", V_TRAP_TO);

        // mem_ready on the exact timeout cycle wins
        do_reset();
        opcode = OP_R; funct = FN_ADD; run = 1'b1; mem_ready = 1'b0;
        cycle("edge_idle", V_IDLE);
        repeat (4) cycle("edge_fetch", V_FETCH);
        mem_ready = 1'b1;
        cycle("edge_fetch_rdy", V_FETCH_RDY);
        cycle("edge_dec", V_DECODE);
        cycle("edge_exec", V_EXEC_R);
        cycle("edge_wb", V_WB_R);
        check("edge_cnt", instr_count, 32'd1);

        // asynchronous reset in the middle of a write
        opcode = OP_SW;
        cycle("ar_fetch", V_FETCH_RDY);
        cycle("ar_dec", V_DECODE);
        cycle("ar_addr", V_ADDR);
        mem_ready = 1'b0;
        @(negedge clk);
        check("ar_memwr", {13'b0, out_vec}, {13'b0, V_MEM_WR});
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_memwrite", {31'b0, MemWrite}, 32'd0);
        check("ar_vec", {13'b0, out_vec}, 32'd0);
        check("ar_cnt", instr_count, 32'd0);
        check("ar_state", {28'b0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b0;
        cycle("ar_idle", V_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the shared single-ALU, single-memory datapath; replaces per-instruction combinational decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback.
- Supports the existing ISA subset: R-type ADD (opcode 000001, funct 100000), LW (000100) and SW (000010), all using ALU_Control 0101 (add).
- Adds a memory ready handshake, a memory timeout trap and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles in any memory state before trapping; 0 disables the timeout.
- CNT_W, 32: width of instr_count.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  enable instruction sequencing; sampled in IDLE and at instruction completion
- opcode  in  6  instruction opcode from IR; stable from DECODE until instruction completion
- funct  in  6  R-type function field from IR
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  load PC with ALU result (PC+4)
- IRWrite  out  1  load IR from memory data
- IorD  out  1  0 = memory address from PC, 1 = memory address from ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemToReg  out  1  register write data: 1 = MDR, 0 = ALUOut
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU operand A: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate
- ALU_Control  out  4  ALU operation code
- busy  out  1  high in every state except IDLE and TRAP
- illegal  out  1  trap flag
- trap_cause  out  2  00 = none, 01 = illegal instruction, 10 = memory timeout
- instr_count  out  CNT_W  number of retired instructions

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, wait counter = 0, instr_count = 0, trap_cause = 00.
  - Every output is 0 while in reset and in IDLE.
- Output timing: outputs decode combinationally from the registered state, plus mem_ready where noted. Any output not listed for a state is 0; no x is ever driven.
- IDLE: go to FETCH when run = 1.
- FETCH:
  - IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALU_Control = 0101.
  - IRWrite = PCWrite = mem_ready.
  - Go to DECODE on mem_ready; otherwise stay.
- DECODE: all enables 0; branch on the opcode/funct presented this cycle.
  - opcode 000001 with funct 100000 → EXEC_R.
  - opcode 000100 or 000010 → ADDR.
  - Anything else → TRAP with cause 01.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALU_Control = 0101 → WB_R.
- WB_R: RegDst = 1, MemToReg = 0, RegWrite = 1 → DONE path.
- ADDR: ALUSrcA = 1, ALUSrcB = 10, ALU_Control = 0101 → MEM_RD if opcode = 000100, else MEM_WR.
- MEM_RD: IorD = 1, MemRead = 1; go to WB_LD on mem_ready.
- WB_LD: RegDst = 0, MemToReg = 1, RegWrite = 1 → DONE path.
- MEM_WR: IorD = 1, MemWrite = 1; on mem_ready take the DONE path.
- DONE path (not a separate state):
  - instr_count increments by 1, wrapping at 2^CNT_W.
  - Next state is FETCH if run = 1, else IDLE.
  - Dropping run never aborts an instruction in flight.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Clears on entering any of these states and on mem_ready.
  - Otherwise increments each cycle.
  - If MEM_TIMEOUT ≠ 0 and the counter equals MEM_TIMEOUT while mem_ready = 0, next state is TRAP with cause 10.
  - mem_ready in the same cycle as the timeout wins: the normal transition is taken.
- TRAP:
  - illegal = 1, trap_cause held, all enables 0.
  - Exits only through reset; run is ignored.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset mid-instruction: immediate return to IDLE with outputs 0. A partial memory write is the memory's responsibility; the controller guarantees MemWrite falls asynchronously with reset.
- Latency with mem_ready tied high:
  - ADD: 4 cycles (FETCH, DECODE, EXEC_R, WB_R).
  - LW: 5 cycles (FETCH, DECODE, ADDR, MEM_RD, WB_LD).
  - SW: 4 cycles (FETCH, DECODE, ADDR, MEM_WR).
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, then run = 1 with ADD (000001/100000) and mem_ready = 1 → exactly 4 cycles; FETCH shows IRWrite = PCWrite = 1 and ALUSrcB = 01; WB_R shows RegDst = 1 and RegWrite = 1; instr_count = 1.
- LW with mem_ready low for 3 cycles in MEM_RD → 8 cycles total; MemRead = IorD = 1 held across the wait; WB_LD shows MemToReg = RegWrite = 1 and RegDst = 0.
- SW, then drop run during MEM_WR → MemWrite = 1 until mem_ready, then IDLE with all outputs 0 and instr_count incremented.
- opcode 111111, or opcode 000001 with funct 000000 → TRAP after DECODE; illegal = 1, trap_cause = 01, no RegWrite/MemWrite pulse; run toggling leaves the block in TRAP.
- MEM_TIMEOUT = 4, mem_ready held low in FETCH → TRAP after the wait counter reaches 4, trap_cause = 10; repeat with mem_ready = 1 on that exact cycle → DECODE entered, no trap.
- Assert rst_n = 0 mid-MEM_WR → MemWrite drops without waiting for clk; state returns to IDLE, instr_count = 0, trap_cause = 00.
